// File: rtl/game_flow_ctrl.sv
// Game flow controller: overlap counting, lives, score and scroll offset.
// Single clock domain, driven by the sync generator's pixel counters.
module game_flow_ctrl #(
  parameter int SCROLL_STEP   = 4,
  parameter int SCROLL_WRAP   = 400,
  parameter int LIVES_INIT    = 3,
  parameter int HIT_THRESH    = 8,
  parameter int INVULN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_active,
  input  logic       draw_sin,
  input  logic       draw_player,
  input  logic       start_btn,
  output logic [9:0] x_offset,
  output logic       game_started,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       game_over,
  output logic       hit_flash
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HIT,
    OVER
  } state_t;

  state_t      state, state_n;
  logic        s1, s2, s3;
  logic        v1, v2, armed;
  logic        start_edge;
  logic [7:0]  ovl;
  logic [7:0]  inv, inv_n;
  logic [9:0]  xo, xo_n;
  logic [1:0]  lv, lv_n;
  logic [7:0]  sc, sc_n;
  logic        frame_end;
  logic        hit_px;
  logic [10:0] sum;
  logic        wrap;
  logic [9:0]  xo_adv;
  logic [7:0]  sc_adv;

  assign frame_end = (pix_x == 10'd640) && (pix_y == 10'd480);
  assign hit_px    = video_active & draw_sin & draw_player;

  // armed blocks a button already held at reset release from starting a game
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      armed      <= 1'b0;
      start_edge <= 1'b0;
    end else begin
      s1         <= start_btn;
      s2         <= s1;
      s3         <= s2;
      v1         <= 1'b1;
      v2         <= v1;
      armed      <= armed | (v2 & ~s2);
      start_edge <= s2 & ~s3 & armed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovl <= 8'd0;
    end else if (frame_end) begin
      ovl <= 8'd0;
    end else if (hit_px && ovl != 8'hFF) begin
      ovl <= ovl + 8'd1;
    end
  end

  assign sum    = {1'b0, xo} + 11'(SCROLL_STEP);
  assign wrap   = sum >= 11'(SCROLL_WRAP);
  assign xo_adv = wrap ? 10'(sum - 11'(SCROLL_WRAP)) : sum[9:0];
  assign sc_adv = (wrap && sc != 8'hFF) ? sc + 8'd1 : sc;

  always_comb begin
    state_n = state;
    xo_n    = xo;
    lv_n    = lv;
    sc_n    = sc;
    inv_n   = inv;
    unique case (state)
      IDLE, OVER: begin
        if (start_edge) begin
          state_n = RUN;
          xo_n    = 10'd0;
          lv_n    = 2'(LIVES_INIT);
          sc_n    = 8'd0;
          inv_n   = 8'd0;
        end
      end
      RUN: begin
        if (frame_end) begin
          xo_n = xo_adv;
          sc_n = sc_adv;
          if (ovl >= 8'(HIT_THRESH)) begin
            if (lv <= 2'd1) begin
              lv_n    = 2'd0;
              state_n = OVER;
            end else begin
              lv_n    = lv - 2'd1;
              inv_n   = 8'(INVULN_FRAMES);
              state_n = HIT;
            end
          end
        end
      end
      HIT: begin
        if (frame_end) begin
          xo_n  = xo_adv;
          sc_n  = sc_adv;
          inv_n = inv - 8'd1;
          if (inv <= 8'd1) begin
            inv_n   = 8'd0;
            state_n = RUN;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      xo    <= 10'd0;
      lv    <= 2'd0;
      sc    <= 8'd0;
      inv   <= 8'd0;
    end else begin
      state <= state_n;
      xo    <= xo_n;
      lv    <= lv_n;
      sc    <= sc_n;
      inv   <= inv_n;
    end
  end

  assign x_offset     = xo;
  assign lives        = lv;
  assign score        = sc;
  assign game_started = (state != IDLE);
  assign game_over    = (state == OVER);
  assign hit_flash    = (state == HIT) & inv[3];

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: vector table of frame runs plus
// hand-written start, restart and mid-game reset sequences.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] pix_x = 10'd0;
  logic [9:0] pix_y = 10'd0;
  logic       video_active = 1'b0;
  logic       draw_sin = 1'b0;
  logic       draw_player = 1'b0;
  logic       start_btn = 1'b0;
  logic [9:0] x_offset;
  logic       game_started;
  logic [1:0] lives;
  logic [7:0] score;
  logic       game_over;
  logic       hit_flash;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int n_ovl;
    int frames;
    int x;
    int lv;
    int sc;
    int st;
    int ov;
    int fl;
  } vec_t;

  vec_t tbl[13];

  game_flow_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .video_active(video_active),
    .draw_sin    (draw_sin),
    .draw_player (draw_player),
    .start_btn   (start_btn),
    .x_offset    (x_offset),
    .game_started(game_started),
    .lives       (lives),
    .score       (score),
    .game_over   (game_over),
    .hit_flash   (hit_flash)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input int x, input int lv,
                         input int sc, input int st, input int ov,
                         input int fl);
    chk($sformatf("%s.x_offset", tag), int'(x_offset), x);
    chk($sformatf("%s.lives", tag), int'(lives), lv);
    chk($sformatf("%s.score", tag), int'(score), sc);
    chk($sformatf("%s.started", tag), int'(game_started), st);
    chk($sformatf("%s.over", tag), int'(game_over), ov);
    chk($sformatf("%s.flash", tag), int'(hit_flash), fl);
  endtask

  task automatic run_frame(input int n);
    for (int i = 0; i < n; i++) begin
      video_active = 1'b1;
      draw_sin     = 1'b1;
      draw_player  = 1'b1;
      tick();
    end
    video_active = 1'b0;
    draw_sin     = 1'b0;
    draw_player  = 1'b0;
    pix_x = 10'd640;
    pix_y = 10'd480;
    tick();
    pix_x = 10'd0;
    pix_y = 10'd0;
  endtask

  initial begin
    tbl[0]  = '{0,   99, 396, 3, 0, 1, 0, 0};
    tbl[1]  = '{0,   1,  0,   3, 1, 1, 0, 0};
    tbl[2]  = '{7,   1,  4,   3, 1, 1, 0, 0};
    tbl[3]  = '{8,   1,  8,   2, 1, 1, 0, 1};
    tbl[4]  = '{200, 4,  24,  2, 1, 1, 0, 1};
    tbl[5]  = '{200, 1,  28,  2, 1, 1, 0, 0};
    tbl[6]  = '{200, 8,  60,  2, 1, 1, 0, 1};
    tbl[7]  = '{200, 46, 244, 2, 1, 1, 0, 0};
    tbl[8]  = '{200, 1,  248, 2, 1, 1, 0, 0};
    tbl[9]  = '{8,   1,  252, 1, 1, 1, 0, 1};
    tbl[10] = '{0,   60, 92,  1, 2, 1, 0, 0};
    tbl[11] = '{300, 1,  96,  0, 2, 1, 1, 0};
    tbl[12] = '{0,   10, 96,  0, 2, 1, 1, 0};

    #1 rst_n = 1'b0;
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (5) tick();

    start_btn = 1'b1;
    repeat (3) tick();
    chk("start.lat3", int'(game_started), 0);
    tick();
    chk("start.lat4", int'(game_started), 1);
    tick();
    start_btn = 1'b0;
    chk_all("start", 0, 3, 0, 1, 0, 0);

    for (int s = 0; s < 13; s++) begin
      for (int f = 0; f < tbl[s].frames; f++) run_frame(tbl[s].n_ovl);
      chk_all($sformatf("vec%0d", s), tbl[s].x, tbl[s].lv, tbl[s].sc,
              tbl[s].st, tbl[s].ov, tbl[s].fl);
    end

    start_btn = 1'b1;
    repeat (4) tick();
    start_btn = 1'b0;
    chk_all("restart", 0, 3, 0, 1, 0, 0);
    tick();

    repeat (3) run_frame(0);
    start_btn = 1'b1;
    repeat (2) tick();
    start_btn = 1'b0;
    repeat (6) tick();
    chk_all("ignore_start", 12, 3, 0, 1, 0, 0);

    run_frame(8);
    chk_all("hit2", 16, 2, 0, 1, 0, 1);
    repeat (3) tick();
    rst_n     = 1'b0;
    start_btn = 1'b1;
    #2;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("held_btn", int'(game_started), 0);
    start_btn = 1'b0;
    repeat (4) tick();
    start_btn = 1'b1;
    repeat (3) tick();
    chk("rearm.lat3", int'(game_started), 0);
    tick();
    start_btn = 1'b0;
    chk_all("rearm", 0, 3, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Downstream of the sine-wave scene and "UW" player renderers, in the `clk` domain.
- Per frame, counts pixels where the player overlaps the sine bars. Turns that into hits, lives, score and a game state machine.
- Generates the scroll offset `x_offset` that feeds back into the scene and player-height lookup. This replaces the vsync-clocked animation register with a clean single-clock design.

Parameters:
- SCROLL_STEP, 4, `x_offset` increment per frame.
- SCROLL_WRAP, 400, modulus of `x_offset`.
- LIVES_INIT, 3, lives loaded at game start (1..3).
- HIT_THRESH, 8, minimum overlap pixels in one frame that count as a hit.
- INVULN_FRAMES, 60, frames of invulnerability after a non-fatal hit (1..255).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_x  in  10  horizontal counter from sync generator (0..799).
- pix_y  in  10  vertical counter from sync generator (0..524).
- video_active  in  1  display enable.
- draw_sin  in  1  sine-bar pixel from scene.
- draw_player  in  1  player pixel.
- start_btn  in  1  asynchronous start button, active-high.
- x_offset  out  10  scroll offset, 0..SCROLL_WRAP-1.
- game_started  out  1  high in RUN/HIT/OVER.
- lives  out  2  remaining lives.
- score  out  8  completed scroll laps, saturating at 255.
- game_over  out  1  high in OVER.
- hit_flash  out  1  player blink enable during invulnerability.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, overlap count 0, invulnerability counter 0, synchronizer flops 0.
- `start_btn`: 2-FF synchronizer, then rising-edge detect. `start_edge` is a 1-cycle pulse 3 clocks after the input rises.
- frame_end: 1-cycle strobe when pix_x==640 && pix_y==480. This falls in blanking, so it never coincides with a counted pixel.
- Overlap counter `ovl`, 8 bits:
  - increments on cycles with video_active && draw_sin && draw_player, saturating at 255;
  - cleared on frame_end (after being sampled that same cycle);
  - counts in every state, but is only acted on in RUN.
- States:
  - IDLE:
    - x_offset=0, game_started=0.
    - start_edge → RUN. Load lives=LIVES_INIT, score=0, x_offset=0.
  - RUN, on frame_end:
    - x_offset ← x_offset+SCROLL_STEP. If the result ≥ SCROLL_WRAP, it becomes result−SCROLL_WRAP and score increments (saturating at 255).
    - If ovl ≥ HIT_THRESH: lives decrements.
      - Lives was 1 → OVER (lives=0).
      - Otherwise → HIT, invuln counter ← INVULN_FRAMES.
  - HIT:
    - x_offset and score advance as in RUN; ovl is ignored.
    - On each frame_end the counter decrements. Going 1→0 returns to RUN (effective next frame_end).
    - hit_flash = counter[3].
  - OVER:
    - x_offset, score and lives frozen; game_over=1.
    - start_edge → RUN with the same reload as from IDLE.
- start_edge in RUN or HIT is ignored.
- All outputs are registered and update the clock after frame_end or start_edge. Latency from frame_end to new x_offset is 1 clock.
- hit_flash=0 outside HIT; game_over=0 outside OVER.
- Reset asserted mid-game returns to IDLE immediately (asynchronous), with no partial update.

Test Plan:
- Reset, pulse start_btn high for 5 clocks → game_started=1 after 4 clocks; lives=3, score=0, x_offset=0.
- RUN with no overlap for 100 frames → x_offset steps 4 per frame: 396→0 at frame 100, score=1, lives=3.
- RUN, force draw_sin=draw_player=1 for 7 active pixels in one frame → no hit. With 8 pixels → lives 3→2, state HIT, hit_flash toggles every 8 frames.
- In HIT, force 200 overlap pixels per frame for 59 frames → lives stays 2. Overlap in frame 61 → lives=1.
- lives=1, hit → game_over=1, lives=0. x_offset frozen for 10 frames. start pulse → RUN with lives=3, score=0, x_offset=0.
- Assert rst_n=0 mid-HIT between frame_ends → all outputs 0 within the same cycle, state IDLE. start_btn held high through reset release must not start the game until it goes low then high.
